sqrt_engine: RTL and testbench

Hardware responder for the Start/Ack program-launch handshake used by the project test benches. It implements program 3, 8-bit floor square root of a 16-bit operand, as a dedicated sequential engine rather than as software on the CPU. It sits where the CPU sits: the bench preloads data memory, releases Start and waits for Ack. The engine then reads the operand bytes from data memory, iterates, and writes the result byte back to data memory.

---
 rtl/sqrt_engine.sv | 121 ++++++++++++
 tb/tb_sqrt_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_engine.sv
// Program-3 responder for the Start/Ack launch handshake: reads a 16-bit operand
// from data memory, computes floor(sqrt) one digit per cycle, writes the 8-bit root back.
module sqrt_engine #(
  parameter int ADDR_W     = 8,
  parameter int OP_HI_ADDR = 16,
  parameter int OP_LO_ADDR = 17,
  parameter int RES_ADDR   = 18
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [7:0]        MemWrData,
  input  logic [7:0]        MemRdData
);

  typedef enum logic [2:0] {
    IDLE, ARMED, RD_HI, RD_LO, CALC, WR, DONE
  } state_t;

  state_t      state_reg;
  logic [15:0] op_reg;
  logic [7:0]  root_reg;
  logic [10:0] rem_reg;
  logic [2:0]  iter_reg;
  logic        ack_reg;

  logic [2:0]  digit_idx;
  logic [1:0]  pair;
  logic [10:0] rem_shift;
  logic [10:0] trial;
  logic        take_digit;
  logic        unused_rem_top;

  // Operand pairs are consumed most-significant first.
  always_comb begin
    digit_idx  = 3'd7 - iter_reg;
    pair       = op_reg[{digit_idx, 1'b0} +: 2];
    rem_shift  = {rem_reg[8:0], pair};
    trial      = {1'b0, root_reg, 2'b01};
    take_digit = (rem_shift >= trial);
  end

  // rem never exceeds 2*root, so its top two bits are always zero.
  assign unused_rem_top = &{1'b0, rem_reg[10:9]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      root_reg  <= '0;
      rem_reg   <= '0;
      iter_reg  <= '0;
      ack_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) state_reg <= ARMED;
        end
        ARMED: begin
          if (!Start) state_reg <= RD_HI;
        end
        RD_HI: begin
          op_reg[15:8] <= MemRdData;
          state_reg    <= RD_LO;
        end
        RD_LO: begin
          op_reg[7:0] <= MemRdData;
          root_reg    <= '0;
          rem_reg     <= '0;
          iter_reg    <= '0;
          state_reg   <= CALC;
        end
        CALC: begin
          if (take_digit) begin
            rem_reg  <= rem_shift - trial;
            root_reg <= {root_reg[6:0], 1'b1};
          end else begin
            rem_reg  <= rem_shift;
            root_reg <= {root_reg[6:0], 1'b0};
          end
          iter_reg <= iter_reg + 3'd1;
          if (iter_reg == 3'd7) state_reg <= WR;
        end
        WR: begin
          ack_reg   <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (Start) begin
            ack_reg   <= 1'b0;
            state_reg <= ARMED;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Ack = ack_reg;

  // Write enable is masked by Reset so a reset landing in WR suppresses the write.
  always_comb begin
    MemAddr   = '0;
    MemWrEn   = 1'b0;
    MemWrData = '0;
    case (state_reg)
      RD_HI: MemAddr = ADDR_W'(OP_HI_ADDR);
      RD_LO: MemAddr = ADDR_W'(OP_LO_ADDR);
      WR: begin
        MemAddr   = ADDR_W'(RES_ADDR);
        MemWrEn   = !Reset;
        MemWrData = root_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sqrt_engine.sv
// Directed bench for sqrt_engine: data-memory model, handshake driver,
// latency/write checks per run and a floor(sqrt) reference for the sweep.
module tb_sqrt_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Ack;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  logic [7:0] dm [0:255];
  int wr_total = 0;
  int errors = 0;
  int checks = 0;

  sqrt_engine dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData),
    .MemRdData(MemRdData)
  );

  always #5 Clk = ~Clk;

  assign MemRdData = dm[MemAddr];

  always @(posedge Clk) begin
    if (MemWrEn) begin
      dm[MemAddr] <= MemWrData;
      wr_total = wr_total + 1;
    end
  end

  function automatic logic [7:0] ref_sqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return 8'(r);
  endfunction

  // Load operand, hold Start for 3 edges, drop it, then watch 12 edges from E0.
  task automatic run_op(input logic [15:0] op, output logic [7:0] res,
                        output bit timing_ok, output int wr_cnt, output logic ack_first);
    int wr_before;
    @(negedge Clk);
    dm[16] = op[15:8];
    dm[17] = op[7:0];
    Start = 1'b1;
    @(posedge Clk); #1;
    ack_first = Ack;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    wr_before = wr_total;
    timing_ok = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(posedge Clk); #1;
      if (MemWrEn !== (k == 10) || Ack !== (k == 11)) timing_ok = 1'b0;
    end
    wr_cnt = wr_total - wr_before;
    res = dm[18];
  endtask

  task automatic check_run(input string name, input logic [15:0] op, input logic [7:0] exp_res);
    logic [7:0] res; bit tok; int wc; logic af;
    run_op(op, res, tok, wc, af);
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s result op=%0d got=0x%02h exp=0x%02h", name, op, res, exp_res);
    end
    checks++;
    if (!tok || wc != 1) begin
      errors++;
      $display("FAIL %s timing op=%0d timing_ok=%0d writes=%0d exp timing_ok=1 writes=1", name, op, tok, wc);
    end
    $display("run %s op=%0d res=0x%02h exp=0x%02h", name, op, res, exp_res);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (Ack !== 1'b0 || MemWrEn !== 1'b0 || MemAddr !== 8'h00 || MemWrData !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b wren=%b addr=%h wdata=%h exp all zero", Ack, MemWrEn, MemAddr, MemWrData);
    end
    @(negedge Clk);
    Reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    dm[18] = 8'h00;
    check_run("op190", 16'd190, 8'h0D);
  endtask

  task automatic test_boundaries;
    check_run("op0", 16'd0, 8'h00);
    check_run("op1", 16'd1, 8'h01);
    check_run("op65535", 16'd65535, 8'hFF);
    check_run("op65025", 16'd65025, 8'hFF);
    check_run("op65024", 16'd65024, 8'hFE);
  endtask

  task automatic test_reset_mid_calc;
    int wr_before;
    @(negedge Clk);
    dm[16] = 8'h00; dm[17] = 8'd200; dm[18] = 8'hAA;
    Start = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    wr_before = wr_total;
    repeat (7) @(posedge Clk);   // E0..E6: now in CALC at iteration 4
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (Ack !== 1'b0 || MemWrEn !== 1'b0 || MemAddr !== 8'h00) begin
      errors++;
      $display("FAIL midcalc_reset got ack=%b wren=%b addr=%h exp 0 0 00", Ack, MemWrEn, MemAddr);
    end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (15) @(posedge Clk);
    #1;
    checks++;
    if (dm[18] !== 8'hAA || wr_total != wr_before || Ack !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_nowrite got dm18=0x%02h writes=%0d ack=%b exp 0xAA 0 0", dm[18], wr_total - wr_before, Ack);
    end
    $display("test_reset_mid_calc dm18=0x%02h", dm[18]);
    check_run("op144", 16'd144, 8'h0C);
  endtask

  task automatic test_back_to_back;
    logic [7:0] res; bit tok; int wc; logic af;
    check_run("b2b_190", 16'd190, 8'h0D);
    checks++;
    if (Ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack_hold got=%b exp=1", Ack);
    end
    run_op(16'd10000, res, tok, wc, af);
    checks++;
    if (af !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_drop got=%b exp=0", af);
    end
    checks++;
    if (res !== 8'h64 || !tok || wc != 1) begin
      errors++;
      $display("FAIL b2b_10000 got res=0x%02h timing_ok=%0d writes=%0d exp 0x64 1 1", res, tok, wc);
    end
    $display("run b2b op=10000 res=0x%02h exp=0x64", res);
  endtask

  task automatic test_idle_no_start;
    bit bad = 1'b0;
    int wr_before;
    @(negedge Clk);
    Start = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    wr_before = wr_total;
    for (int k = 0; k < 50; k++) begin
      @(posedge Clk); #1;
      if (MemWrEn !== 1'b0 || Ack !== 1'b0 || MemAddr !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad || wr_total != wr_before) begin
      errors++;
      $display("FAIL idle_no_start got activity=%0d writes=%0d exp 0 0", bad, wr_total - wr_before);
    end
    $display("test_idle_no_start done");
  endtask

  task automatic test_random_sweep;
    logic [7:0] res; bit tok; int wc; logic af;
    logic [15:0] op;
    int sweep_bad = 0;
    for (int n = 0; n < 1000; n++) begin
      op = 16'($urandom_range(0, 65535));
      run_op(op, res, tok, wc, af);
      checks++;
      if (res !== ref_sqrt(int'(op)) || !tok || wc != 1 || (n > 0 && af !== 1'b0)) begin
        errors++;
        sweep_bad++;
        $display("FAIL sweep op=%0d got=0x%02h exp=0x%02h timing_ok=%0d writes=%0d", op, res, ref_sqrt(int'(op)), tok, wc);
      end
    end
    $display("test_random_sweep 1000 operands, %0d bad", sweep_bad);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dm[i] = 8'h00;
    test_reset;
    test_basic;
    test_boundaries;
    test_reset_mid_calc;
    test_back_to_back;
    test_idle_no_start;
    test_random_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
